// File: rtl/ibex_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ibex_mem_port_arbiter - fetch/LSU arbiter for one req/gnt/rvalid memory port
// Define IBEX_MEM_ARB_RR_EN for round-robin priority (default LS over IF). Rev 1.0
// ----------------------------------------------------------------------------
module ibex_mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ls_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              busy_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic owner;
    logic discard;
  } owner_entry_t;

  arb_state_e        state_q, state_d;
  logic              lock_q, lock_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              hold_we_q, hold_we_d;
  logic [3:0]        hold_be_q, hold_be_d;
  logic [31:0]       hold_wdata_q, hold_wdata_d;

  owner_entry_t [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              sel_owner, cur_owner, cur_req_live;
  logic              fifo_empty, fifo_full, push, pop;
  logic              req_int, we_int;
  logic [ADDR_W-1:0] addr_int, if_addr_aligned;
  logic [3:0]        be_int;
  logic [31:0]       wdata_int;
  owner_entry_t      head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef IBEX_MEM_ARB_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    if (if_req_i && ls_req_i) sel_owner = rr_q;
    else                      sel_owner = ls_req_i ? OWNER_LS : OWNER_IF;
  end

  // Preference moves away from a requester only once it has actually been served.
  always_comb begin
    rr_d = rr_q;
    if (push && (cur_owner == rr_q)) rr_d = ~rr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= OWNER_LS;
    else         rr_q <= rr_d;
  end
`else
  always_comb begin
    sel_owner = ls_req_i ? OWNER_LS : OWNER_IF;
  end
`endif

  assign if_addr_aligned = if_addr_i & ~ADDR_W'(3);
  assign fifo_empty      = (count_q == '0);
  assign pop             = mem_rvalid_i & ~fifo_empty;
  // A response this cycle frees a slot, so a full FIFO may still accept a grant.
  assign fifo_full       = (count_q == CNT_W'(MAX_OUTSTANDING)) & ~mem_rvalid_i;
  assign cur_owner       = (state_q == ARB_HOLD) ? lock_q : sel_owner;
  assign cur_req_live    = (cur_owner == OWNER_LS) ? ls_req_i : if_req_i;
  assign push            = req_int & mem_gnt_i;
  assign head            = fifo_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    hold_addr_d  = hold_addr_q;
    hold_we_d    = hold_we_q;
    hold_be_d    = hold_be_q;
    hold_wdata_d = hold_wdata_q;
    req_int      = 1'b0;
    addr_int     = '0;
    we_int       = 1'b0;
    be_int       = 4'h0;
    wdata_int    = '0;
    case (state_q)
      ARB_IDLE: begin
        if ((if_req_i | ls_req_i) & ~fifo_full) begin
          req_int = 1'b1;
          if (sel_owner == OWNER_LS) begin
            addr_int  = ls_addr_i;
            we_int    = ls_we_i;
            be_int    = ls_be_i;
            wdata_int = ls_wdata_i;
          end else begin
            addr_int  = if_addr_aligned;
            be_int    = 4'hF;
          end
          if (!mem_gnt_i) begin
            state_d      = ARB_HOLD;
            lock_d       = sel_owner;
            hold_addr_d  = addr_int;
            hold_we_d    = we_int;
            hold_be_d    = be_int;
            hold_wdata_d = wdata_int;
          end
        end
      end
      ARB_HOLD: begin
        // The request is never withdrawn, even if the owner has dropped req.
        req_int   = ~fifo_full;
        addr_int  = hold_addr_q;
        we_int    = hold_we_q;
        be_int    = hold_be_q;
        wdata_int = hold_wdata_q;
        if (req_int && mem_gnt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q].owner   = cur_owner;
      fifo_d[wr_ptr_q].discard = ~cur_req_live;
      wr_ptr_d                 = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      lock_q       <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= 4'h0;
      hold_wdata_q <= '0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      hold_addr_q  <= hold_addr_d;
      hold_we_q    <= hold_we_d;
      hold_be_q    <= hold_be_d;
      hold_wdata_q <= hold_wdata_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Outputs are forced low while reset is asserted, independent of the inputs.
  assign mem_req_o   = rst_ni & req_int;
  assign mem_addr_o  = mem_req_o ? addr_int : '0;
  assign mem_we_o    = mem_req_o & we_int;
  assign mem_be_o    = mem_req_o ? be_int : 4'h0;
  assign mem_wdata_o = mem_req_o ? wdata_int : '0;

  assign if_gnt_o    = mem_req_o & mem_gnt_i & (cur_owner == OWNER_IF) & if_req_i;
  assign ls_gnt_o    = mem_req_o & mem_gnt_i & (cur_owner == OWNER_LS) & ls_req_i;
  assign if_rvalid_o = rst_ni & pop & (head.owner == OWNER_IF) & ~head.discard;
  assign ls_rvalid_o = rst_ni & pop & (head.owner == OWNER_LS) & ~head.discard;
  assign if_rdata_o  = rst_ni ? mem_rdata_i : '0;
  assign ls_rdata_o  = rst_ni ? mem_rdata_i : '0;
  assign if_err_o    = rst_ni & mem_err_i;
  assign ls_err_o    = rst_ni & mem_err_i;
  assign busy_o      = rst_ni & ((state_q != ARB_IDLE) | ~fifo_empty | mem_req_o);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && mem_rvalid_i) begin
      assert (count_q != '0)
        else $error("ibex_mem_port_arbiter: rvalid with no outstanding transaction");
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/ibex_mem_port_arbiter.md
Name: ibex_mem_port_arbiter

Overview:
- Shares one external memory port (req/gnt/rvalid protocol) between the instruction-fetch requester (prefetch buffer side) and the load/store requester.
- Sits between the core's fetch and LSU interfaces and the single-port memory or bus.
- Records the owner of every granted transaction in order, so each in-order response (rdata/rvalid/err) is routed back to the requester that issued it.

Parameters:
- ADDR_W, 32, width of all address buses.
- MAX_OUTSTANDING, 2, number of granted-but-unanswered transactions allowed (power of two, 1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch word address
- if_gnt_o  out  1  fetch grant
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  32  fetch response data
- if_err_o  out  1  fetch bus error
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  write enable
- ls_be_i  in  4  byte enables
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  32  write data
- ls_gnt_o  out  1  load/store grant
- ls_rvalid_o  out  1  load/store response valid
- ls_rdata_o  out  32  load/store response data
- ls_err_o  out  1  load/store bus error
- mem_req_o  out  1  shared-port request
- mem_we_o  out  1  shared-port write enable
- mem_be_o  out  4  shared-port byte enables
- mem_addr_o  out  ADDR_W  shared-port address
- mem_wdata_o  out  32  shared-port write data
- mem_gnt_i  in  1  shared-port grant
- mem_rvalid_i  in  1  shared-port response valid
- mem_rdata_i  in  32  shared-port response data
- mem_err_i  in  1  shared-port error
- busy_o  out  1  transaction outstanding or request pending

Behaviour:
- Reset: clk_i clock; rst_ni asynchronous, active-low. All outputs 0. Owner FIFO empty, state ARB_IDLE, lock clear, rr pointer = LS.
- Owner FIFO: MAX_OUTSTANDING entries of 1 bit (0=IF, 1=LS).
  - Push on mem_req_o & mem_gnt_i; pushes the currently selected owner.
  - Pop on mem_rvalid_i.
  - Push and pop in the same cycle is legal, including when full: count is unchanged.
  - mem_rvalid_i with the FIFO empty is a protocol error. Drop the beat and assert it in simulation.
- Full: when count == MAX_OUTSTANDING and there is no pop this cycle, mem_req_o = 0 and both gnt_o = 0.
- Selection (combinational in ARB_IDLE): priority as described under Optional Feature.
- States:
  - ARB_IDLE: if the selected requester is asking and the FIFO is not full, drive mem_req_o = 1 with the selected requester's fields.
    - If mem_gnt_i: stay in ARB_IDLE and push the owner.
    - Otherwise: latch the selection into lock and go to ARB_HOLD.
  - ARB_HOLD: keep driving the locked requester's fields with mem_req_o = 1. The other requester is never granted, so bus request and address stay stable until grant. On mem_gnt_i: push, return to ARB_IDLE.
  - If the locked requester drops req in ARB_HOLD (fetch abort on branch), mem_req_o still stays 1 with the latched address. The arbiter does not withdraw a request. Implement this with an internal address/we/be/wdata hold register captured on entry to ARB_HOLD.
- Grant passthrough: x_gnt_o = mem_gnt_i & mem_req_o & (owner==x) & (requester x req high). A grant to an abandoned locked request is absorbed: push owner with a discard flag.
  - FIFO entries are therefore 2 bits: owner + discard.
  - Discarded responses raise neither rvalid_o.
- Response routing: x_rvalid_o = mem_rvalid_i & head.owner==x & !head.discard. rdata and err are forwarded combinationally to both sides. Zero added latency.
- Fetch side: address bits [1:0] forced to 0 on mem_addr_o. mem_we_o = 0 and mem_be_o = 4'hF for fetch.
- busy_o = state != ARB_IDLE | FIFO non-empty | mem_req_o.

Optional Feature:
- Macro: IBEX_MEM_ARB_RR_EN.
- Defined: round-robin priority. A 1-bit rr pointer names the preferred requester and flips to the other requester after each grant to the preferred one. When both request every cycle, grants alternate LS, IF, LS, ...
- Undefined: fixed priority, LS over IF. The rr pointer is not implemented.

Test Plan:
1. Fetch only:
   - Stimulus: if_req_i=1 with addr 0x1002, mem_gnt_i=1 immediately, rvalid one cycle later with rdata 0xDEADBEEF.
   - Response: mem_addr_o=0x1000, if_gnt_o same cycle, if_rvalid_o/if_rdata_o=0xDEADBEEF next cycle, ls_rvalid_o=0.
2. Contention:
   - Stimulus: both requesting for 4 cycles, gnt always high.
   - Response: RR build gives grant order LS, IF, LS, IF. Fixed build gives LS ×4 and if_gnt_o=0.
3. Grant stall:
   - Stimulus: if_req_i at cycle 0, mem_gnt_i low for 3 cycles, ls_req_i rising at cycle 1.
   - Response: mem_addr_o holds the fetch address in all 4 cycles, ls_gnt_o=0 until after the fetch grant.
4. Full:
   - Stimulus: MAX_OUTSTANDING=2, two granted fetches with no rvalid, third request.
   - Response: mem_req_o=0. On rvalid, push and pop happen in the same cycle, the third request is granted, and count stays 2.
5. Abort:
   - Stimulus: fetch in ARB_HOLD, if_req_i drops, then grant and rvalid arrive.
   - Response: mem_req_o stays 1 with the latched address, and neither rvalid_o pulses.
6. Reset mid-operation:
   - Stimulus: rst_ni low with 2 outstanding and ARB_HOLD active.
   - Response: all outputs 0 immediately; after release, the first new request is routed correctly.
